pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register placed at each inter-stage boundary.
// Control and datapath payloads travel as packed vectors. A two-entry skid
// buffer decouples in_ready from out_ready, so no combinational ready path
// runs back upstream. flush (from the hazard unit) discards held entries and
// leaves an all-zero bubble on the outputs. A zero control word is a no-op.
// Optional feature: define PIPE_STAGE_PERF_EN to build saturating stall/flush
// performance counters; without it the counter ports are tied to zero.

module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 16,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Handshake outputs come only from the state flops; the payload comes
    // straight from the main entry, which is kept at zero whenever empty.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    // Occupancy FSM with main/skid entries; reset and flush both empty the
    // stage and zero every entry so the bubble invariant holds.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        state     <= ONE;
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_valid) begin
                        state     <= FULL;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        main_ctrl <= '0;
                        main_data <= '0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= ONE;
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= '0;
                        skid_data <= '0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_ctrl <= '0;
                    main_data <= '0;
                    skid_ctrl <= '0;
                    skid_data <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

    // Saturating counters for stalled-output cycles and for flushes that
    // actually threw something away; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (flush && (state != EMPTY) && (flush_q != '1)) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg. A two-deep FIFO model
// predicts the outputs every cycle; literal checks pin the model at key points.
// Counter expectations depend on whether PIPE_STAGE_PERF_EN is defined.

module tb_pipe_stage_reg;

    localparam int DW = 160;
    localparam int CW = 16;
    localparam int PW = 4;
    localparam int unsigned SAT = (1 << PW) - 1;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [PW-1:0] stall_cnt;
    logic [PW-1:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    // Free-running clock
    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .PERF_W (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    item_t       mq[$];
    int unsigned mStall = 0;
    int unsigned mFlush = 0;
    bit          live   = 1'b0;
    bit          mHad;
    bit          mRoom;

    function automatic logic [DW-1:0] mkData(input logic [CW-1:0] c);
        return {10{c ^ 16'h5A5A}};
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic [CW-1:0] c, input logic o);
        rst_n     = r;
        flush     = f;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = mkData(c);
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    // Model: the stage behaves as a FIFO of depth two with a zero bubble when empty
    always @(posedge clk) begin
        mHad  = (mq.size() > 0);
        mRoom = (mq.size() < 2);
        if (!rst_n) begin
            mq.delete();
            mStall = 0;
            mFlush = 0;
            live   = 1'b1;
        end else begin
            if (mHad && !out_ready && mStall < SAT) mStall++;
            if (flush && mHad && mFlush < SAT) mFlush++;
            if (flush) begin
                mq.delete();
            end else begin
                if (mHad && out_ready) void'(mq.pop_front());
                if (in_valid && mRoom) mq.push_back(item_t'{c: in_ctrl, d: in_data});
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (live) begin
            checkOutput("out_valid", DW'(out_valid), DW'(mq.size() > 0));
            checkOutput("in_ready", DW'(in_ready), DW'(mq.size() < 2));
            checkOutput("out_ctrl", DW'(out_ctrl), (mq.size() > 0) ? DW'(mq[0].c) : '0);
            checkOutput("out_data", out_data, (mq.size() > 0) ? mq[0].d : '0);
            checkOutput("stall_cnt", DW'(stall_cnt), PERF_ON ? DW'(mStall) : '0);
            checkOutput("flush_cnt", DW'(flush_cnt), PERF_ON ? DW'(mFlush) : '0);
        end
    end

    // Directed scenario sequence with literal expectations
    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0077, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0077, 1'b0);
        checkOutput("rst_valid", DW'(out_valid), '0);
        checkOutput("rst_ctrl", DW'(out_ctrl), '0);
        checkOutput("rst_data", out_data, '0);
        checkOutput("rst_ready", DW'(in_ready), DW'(1));
        checkOutput("rst_stall", DW'(stall_cnt), '0);

        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0001, 1'b1);
        checkOutput("first_valid", DW'(out_valid), DW'(1));
        checkOutput("first_ctrl", DW'(out_ctrl), DW'(16'h0001));
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, CW'(i), 1'b1);
        end
        checkOutput("stream_last_ctrl", DW'(out_ctrl), DW'(16'h0008));
        checkOutput("stream_last_data", out_data, {10{16'h5A52}});
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("stream_end_valid", DW'(out_valid), '0);

        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0011, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0022, 1'b0);
        checkOutput("skid_full_ready", DW'(in_ready), '0);
        checkOutput("skid_hold_ctrl", DW'(out_ctrl), DW'(16'h0011));
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0033, 1'b0);
        checkOutput("skid_c_refused", DW'(out_ctrl), DW'(16'h0011));
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0033, 1'b1);
        checkOutput("skid_b_out", DW'(out_ctrl), DW'(16'h0022));
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0033, 1'b1);
        checkOutput("skid_c_out", DW'(out_ctrl), DW'(16'h0033));
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("skid_drained", DW'(out_valid), '0);

        applyStimulus(1'b1, 1'b0, 1'b1, 16'hABCD, 1'b1);
        checkOutput("drain_ctrl", DW'(out_ctrl), DW'(16'hABCD));
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("bubble_valid", DW'(out_valid), '0);
        checkOutput("bubble_ctrl", DW'(out_ctrl), '0);
        checkOutput("bubble_data", out_data, '0);

        applyStimulus(1'b1, 1'b0, 1'b1, 16'h000A, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h000B, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0044, 1'b0);
        checkOutput("flush_valid", DW'(out_valid), '0);
        checkOutput("flush_ready", DW'(in_ready), DW'(1));
        checkOutput("flush_ctrl", DW'(out_ctrl), '0);
        checkOutput("flush_fcnt", DW'(flush_cnt), PERF_ON ? DW'(1) : '0);
        checkOutput("flush_scnt", DW'(stall_cnt), PERF_ON ? DW'(5) : '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("flush_44_absent", DW'(out_valid), '0);

        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0045, 1'b1);
        checkOutput("flush_empty_fcnt", DW'(flush_cnt), PERF_ON ? DW'(1) : '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0066, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0067, 1'b1);
        checkOutput("flush_one_fcnt", DW'(flush_cnt), PERF_ON ? DW'(2) : '0);
        checkOutput("flush_one_valid", DW'(out_valid), '0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, (i % 4) != 3, CW'(16'h0100 + i), (i % 3) != 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0055, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        end
        checkOutput("sat_stall", DW'(stall_cnt), PERF_ON ? DW'(15) : '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("sat_stall_hold", DW'(stall_cnt), PERF_ON ? DW'(15) : '0);
        checkOutput("sat_ctrl", DW'(out_ctrl), DW'(16'h0055));

        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0099, 1'b0);
        checkOutput("rstflush_fcnt", DW'(flush_cnt), '0);
        checkOutput("rstflush_scnt", DW'(stall_cnt), '0);
        checkOutput("rstflush_valid", DW'(out_valid), '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0012, 1'b1);
        checkOutput("post_rst_ctrl", DW'(out_ctrl), DW'(16'h0012));
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
